lcd_texto_seq: RTL and testbench
================================

Name: lcd_texto_seq

Overview:
- Upstream feeder for the HD44780 LCD controller. It drives the controller's lcd_enable / lcd_bus and consumes its busy.
- Holds a 32-character frame buffer (2 lines x 16), written by the host.
- On request, streams the whole buffer to the display as 34 controller transactions:
  - set-DDRAM 0x80, then 16 characters;
  - set-DDRAM 0xC0, then 16 characters.

Parameters:
- LINE_LEN, 16, characters per line; buffer depth is 2*LINE_LEN, fixed at 32 entries.
- ACK_TIMEOUT, 1000, clk cycles allowed in WAIT_ACK for lcd_busy to rise before the transaction is aborted.
- FILL_CHAR, 8'h20, buffer contents after reset (ASCII space).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  host buffer write strobe.
- wr_addr  in  5  buffer index; 0-15 is line 1, 16-31 is line 2.
- wr_data  in  8  ASCII code to store.
- refresh  in  1  single-cycle pulse requesting a frame transfer.
- lcd_busy  in  1  busy output of the LCD controller.
- lcd_enable  out  1  transaction request to the controller.
- lcd_bus  out  10  {rs, rw, data[7:0]} to the controller.
- seq_busy  out  1  high while a frame transfer is in progress.
- frame_done  out  1  one-cycle pulse when step 33 completes.
- ack_err  out  1  one-cycle pulse on ACK timeout.

Behaviour:
- Reset (async, rst_n=0):
  - lcd_enable=0, lcd_bus=10'h000, seq_busy=0, frame_done=0, ack_err=0.
  - pending=0, step=0, timeout counter=0, state=IDLE.
  - All 32 buffer entries = FILL_CHAR.
- Buffer writes:
  - When wr_en=1, buf[wr_addr] <= wr_data on the same edge, in any state.
  - Characters are read at ISSUE time, so a write during a frame is visible if its step has not yet been issued.
- Refresh:
  - refresh=1 sets pending on that edge, in any state.
  - pending clears on the edge where IDLE starts a frame.
- Steps 0..33, in order:
  - step 0: lcd_bus = 10'h080.
  - steps 1..16: lcd_bus = {2'b10, buf[step-1]}.
  - step 17: lcd_bus = 10'h0C0.
  - steps 18..33: lcd_bus = {2'b10, buf[step-2]}.
  - rw is always 0.
- FSM:
  - IDLE: seq_busy=0. If pending=1 and lcd_busy=0, go to ISSUE with step=0 and seq_busy<=1. While lcd_busy=1 (e.g. controller power-up/init, about 52 ms), remain in IDLE.
  - ISSUE: drive lcd_bus for the current step, set lcd_enable<=1, go to WAIT_ACK. Only entered with lcd_busy=0.
  - WAIT_ACK: hold lcd_enable and lcd_bus. When lcd_busy=1, set lcd_enable<=0 and go to WAIT_DONE.
    - If ACK_TIMEOUT cycles pass without lcd_busy=1: lcd_enable<=0, pulse ack_err, abort the frame (step=0, seq_busy<=0), go to IDLE. pending is kept if it was re-set.
  - WAIT_DONE: when lcd_busy=0, go to NEXT. lcd_bus is held until this exit.
  - NEXT:
    - If step==33: pulse frame_done, go to IDLE. If pending is set, the next frame starts from IDLE.
    - Otherwise step<=step+1 and go to ISSUE if lcd_busy=0, else wait in NEXT.
- Handshake invariants:
  - lcd_enable rises only while lcd_busy=0.
  - lcd_enable is never high in two separate transactions without an intervening lcd_busy high/low cycle.
- Timing:
  - Minimum 4 cycles per transaction plus the controller's busy time.
  - frame_done arrives 1 cycle after the last busy falls.
- Other boundary rules:
  - Step counter is 6 bits and never exceeds 33.
  - refresh in the same cycle as frame_done leaves pending=1, so a second frame follows.
  - A reset mid-frame drops lcd_enable asynchronously and refills the buffer.

Test Plan:
- Reset value check: assert rst_n=0 mid-operation -> all outputs 0 and lcd_bus=10'h000 immediately. After release with refresh pulse and a controller model, the frame shows 0x080, 0x220 x16, 0x0C0, 0x220 x16.
- Write buf[0]=8'h41 and buf[31]=8'h5A, then pulse refresh -> transactions 0x080, 0x241, 0x220 x15, 0x0C0, 0x220 x15, 0x25A. frame_done pulses once, seq_busy=0 afterwards.
- lcd_busy held 1 for 2.6M cycles (init) with refresh pulsed early -> lcd_enable stays 0 until busy falls, then the frame starts.
- Pulse refresh during step 10 -> exactly two frames back-to-back, 68 transactions, two frame_done pulses.
- Controller model never raises busy with ACK_TIMEOUT=8 -> lcd_enable high for 8 cycles then 0, one ack_err pulse, FSM back in IDLE, step restarts at 0x080 on the next refresh.
- Write buf[20]=8'h42 while step 5 is in progress -> step 22 sends 0x242.

Source files
------------

// File: rtl/lcd_texto_seq_if.sv
// Handshake bundle between the text sequencer and the HD44780 controller.
//   lcd_enable : transaction request, raised by the sequencer
//   lcd_bus    : {rs, rw, data[7:0]} presented with the request
//   lcd_busy   : controller busy flag
// Valid/ready semantics: the sequencer raises lcd_enable with lcd_bus stable
// only while lcd_busy is low; the controller accepts by raising lcd_busy,
// after which lcd_enable drops; the transaction completes when lcd_busy falls.
interface lcd_texto_seq_if;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       lcd_busy;

  modport master (output lcd_enable, output lcd_bus, input lcd_busy);
  modport slave  (input lcd_enable, input lcd_bus, output lcd_busy);
endinterface

// File: rtl/lcd_texto_seq.sv
// Frame-buffer feeder for an HD44780 LCD controller.
// Holds 2 x 16 characters written by the host and, on refresh, streams
// them as 34 transactions: 0x080, 16 chars of line 1, 0x0C0, 16 chars of line 2.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   wr_en/wr_addr/wr_data : host write into the frame buffer (any state)
//   refresh             : single-cycle frame request (latched as pending)
//   lcd                 : master side of the controller handshake
//   seq_busy            : high while a frame transfer is in progress
//   frame_done          : one-cycle pulse after the last transaction
//   ack_err             : one-cycle pulse when the controller never acks
//   dbg_state           : current FSM state
module lcd_texto_seq #(
  parameter int          LINE_LEN    = 16,
  parameter int          ACK_TIMEOUT = 1000,
  parameter logic [7:0]  FILL_CHAR   = 8'h20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [4:0]             wr_addr,
  input  logic [7:0]             wr_data,
  input  logic                   refresh,
  lcd_texto_seq_if.master        lcd,
  output logic                   seq_busy,
  output logic                   frame_done,
  output logic                   ack_err,
  output logic [2:0]             dbg_state
);

  localparam int DEPTH = 2 * LINE_LEN;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);

  localparam logic [5:0] LINE2_STEP = 6'(LINE_LEN + 1);
  localparam logic [5:0] LAST_STEP  = 6'(2 * LINE_LEN + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_ACK  = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] NEXT      = 3'd4;

  logic [2:0]    state;
  logic [5:0]    step;
  logic [TW-1:0] to_cnt;
  logic          pending;
  logic [7:0]    char_mem [DEPTH];

  logic [4:0]    char_idx;
  logic [9:0]    issue_word;
  logic          start;

  assign dbg_state = state;
  assign start     = (state == IDLE) && pending && !lcd.lcd_busy;

  // Line 1 chars sit at steps 1..16, line 2 chars at steps 18..33;
  // the second offset skips the 0x0C0 address command.
  always_comb begin
    char_idx   = 5'd0;
    issue_word = 10'h000;
    if (step <= LINE2_STEP) char_idx = 5'(step - 6'd1);
    else                    char_idx = 5'(step - 6'd2);
    if (step == 6'd0)            issue_word = 10'h080;
    else if (step == LINE2_STEP) issue_word = 10'h0C0;
    else                         issue_word = {2'b10, char_mem[char_idx]};
  end

  // Frame buffer: host writes land in any state; read at ISSUE time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) char_mem[i] <= FILL_CHAR;
    end else if (wr_en) begin
      char_mem[wr_addr] <= wr_data;
    end
  end

  // A refresh arriving on the same edge that a frame starts (or ends)
  // must survive, so the set has priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pending <= 1'b0;
    else if (refresh) pending <= 1'b1;
    else if (start)   pending <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      step           <= 6'd0;
      to_cnt         <= '0;
      lcd.lcd_enable <= 1'b0;
      lcd.lcd_bus    <= 10'h000;
      seq_busy       <= 1'b0;
      frame_done     <= 1'b0;
      ack_err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      ack_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            step     <= 6'd0;
            seq_busy <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          lcd.lcd_bus    <= issue_word;
          lcd.lcd_enable <= 1'b1;
          to_cnt         <= '0;
          state          <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (lcd.lcd_busy) begin
            lcd.lcd_enable <= 1'b0;
            state          <= WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            // Controller never accepted: abandon the whole frame.
            lcd.lcd_enable <= 1'b0;
            ack_err        <= 1'b1;
            step           <= 6'd0;
            seq_busy       <= 1'b0;
            state          <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!lcd.lcd_busy) state <= NEXT;
        end
        NEXT: begin
          if (step == LAST_STEP) begin
            frame_done <= 1'b1;
            seq_busy   <= 1'b0;
            step       <= 6'd0;
            state      <= IDLE;
          end else if (!lcd.lcd_busy) begin
            // Advance only when leaving, so waiting here never skips a step.
            step  <= step + 6'd1;
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_texto_seq.sv
module tb_lcd_texto_seq;

  localparam logic [2:0] S_IDLE = 3'd0;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       refresh;
  logic       seq_busy;
  logic       frame_done;
  logic       ack_err;
  logic [2:0] dbg_state;

  lcd_texto_seq_if lif ();

  lcd_texto_seq #(.LINE_LEN(16), .ACK_TIMEOUT(8), .FILL_CHAR(8'h20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .refresh    (refresh),
    .lcd        (lif.master),
    .seq_busy   (seq_busy),
    .frame_done (frame_done),
    .ack_err    (ack_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [9:0] exp_q[$];
  logic [9:0] cap_log[$];
  logic [7:0] shadow [32];
  int n_checks;
  int n_errors;
  int fd_cnt;
  int ae_cnt;
  int en_hi_cnt;
  logic ctrl_on;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // controller model: accept on the negedge after enable is seen, busy 3 cycles
  initial begin
    lif.lcd_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ctrl_on && lif.lcd_enable && !lif.lcd_busy) begin
        cap_log.push_back(lif.lcd_bus);
        if (exp_q.size() > 0) check("xact", {22'd0, lif.lcd_bus}, {22'd0, exp_q.pop_front()});
        else                  check("xact_unexpected", exp_q.size(), 1);
        lif.lcd_busy = 1'b1;
        repeat (3) @(negedge clk);
        lif.lcd_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (frame_done)     fd_cnt++;
    if (ack_err)        ae_cnt++;
    if (lif.lcd_enable) en_hi_cnt++;
  end

  // driver tasks
  task automatic push_frame();
    exp_q.push_back(10'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({2'b10, shadow[i]});
    exp_q.push_back(10'h0C0);
    for (int i = 16; i < 32; i++) exp_q.push_back({2'b10, shadow[i]});
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int target, input int budget);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, fd_cnt, target);
  endtask

  task automatic wait_caps(input string tag, input int target, input int budget);
    int n = 0;
    while (cap_log.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cap_log.size() >= target), 1);
  endtask

  int fd_base;
  int ae_base;
  int cap_base;

  initial begin
    n_checks = 0; n_errors = 0; fd_cnt = 0; ae_cnt = 0; en_hi_cnt = 0;
    ctrl_on = 1'b1;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; refresh = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = 8'h20;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_enable", lif.lcd_enable, 0);
    check("rst_bus", lif.lcd_bus, 10'h000);
    check("rst_seq_busy", seq_busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // reset in the middle of a frame
    push_frame();
    pulse_refresh();
    wait_caps("mid_reset_progress", 4, 200);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_enable", lif.lcd_enable, 0);
    check("midrst_bus", lif.lcd_bus, 10'h000);
    check("midrst_seq_busy", seq_busy, 0);
    repeat (6) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);

    // default frame of spaces after reset
    fd_base = fd_cnt;
    push_frame();
    pulse_refresh();
    wait_fd("fd_default", fd_base + 1, 2000);
    check("default_q_empty", exp_q.size(), 0);

    // two characters written at the ends of the buffer
    write_buf(5'd0, 8'h41);
    write_buf(5'd31, 8'h5A);
    shadow[0] = 8'h41;
    shadow[31] = 8'h5A;
    fd_base = fd_cnt;
    push_frame();
    pulse_refresh();
    wait_fd("fd_ends", fd_base + 1, 2000);
    repeat (5) @(negedge clk);
    check("ends_single_fd", fd_cnt, fd_base + 1);
    check("ends_seq_busy", seq_busy, 0);
    check("ends_q_empty", exp_q.size(), 0);

    // controller held busy (power-up init) with refresh already pending
    ctrl_on = 1'b0;
    lif.lcd_busy = 1'b1;
    en_hi_cnt = 0;
    pulse_refresh();
    repeat (2000) @(negedge clk);
    check("init_enable_low", en_hi_cnt, 0);
    check("init_state_idle", dbg_state, S_IDLE);
    fd_base = fd_cnt;
    push_frame();
    lif.lcd_busy = 1'b0;
    ctrl_on = 1'b1;
    wait_fd("fd_after_init", fd_base + 1, 2000);

    // refresh during step 10 chains a second frame
    fd_base = fd_cnt;
    cap_base = cap_log.size();
    push_frame();
    push_frame();
    pulse_refresh();
    wait_caps("step10_reach", cap_base + 11, 500);
    pulse_refresh();
    wait_fd("fd_two_frames", fd_base + 2, 4000);
    repeat (20) @(negedge clk);
    check("two_frames_fd", fd_cnt, fd_base + 2);
    check("two_frames_xacts", cap_log.size() - cap_base, 68);
    check("two_frames_q_empty", exp_q.size(), 0);

    // controller never acknowledges
    ctrl_on = 1'b0;
    en_hi_cnt = 0;
    ae_base = ae_cnt;
    pulse_refresh();
    repeat (30) @(negedge clk);
    check("to_enable_cycles", en_hi_cnt, 8);
    check("to_ack_err", ae_cnt, ae_base + 1);
    check("to_state_idle", dbg_state, S_IDLE);
    check("to_seq_busy", seq_busy, 0);
    check("to_enable_low", lif.lcd_enable, 0);
    ctrl_on = 1'b1;
    fd_base = fd_cnt;
    push_frame();
    pulse_refresh();
    wait_fd("fd_after_timeout", fd_base + 1, 2000);

    // write during the frame reaches a not-yet-issued step
    shadow[20] = 8'h42;
    fd_base = fd_cnt;
    cap_base = cap_log.size();
    push_frame();
    pulse_refresh();
    wait_caps("step5_reach", cap_base + 6, 500);
    write_buf(5'd20, 8'h42);
    wait_fd("fd_late_write", fd_base + 1, 2000);
    if (cap_log.size() >= cap_base + 23) check("late_write_step22", {22'd0, cap_log[cap_base + 22]}, 32'h242);
    else                                 check("late_write_caps", cap_log.size(), cap_base + 23);
    check("late_write_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
